// File: rtl/cache_structs_def.sv
// cache_structs_def: shared types and limits for the memory-side cache infrastructure
package cache_structs_def;
    typedef enum logic [1:0] {ARB_IDLE, ARB_BUSY, ARB_RESP} arb_state_e;
    localparam int ARB_MAX_REQ = 8;
endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: requester-side and mem_ctrl-side signals of the shared memory port
interface mem_port_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int N_REQ = 2
);
    localparam int IW = $clog2(N_REQ);
    logic [N_REQ-1:0]            req_valid;
    logic [N_REQ-1:0]            req_rw;
    logic [N_REQ*ADDR_WIDTH-1:0] req_addr;
    logic [N_REQ*DATA_WIDTH-1:0] req_wdata;
    logic [N_REQ-1:0]            req_ack;
    logic [N_REQ-1:0]            req_err;
    logic [DATA_WIDTH-1:0]       rsp_rdata;
    logic                        mem_valid;
    logic                        mem_rw;
    logic [ADDR_WIDTH-1:0]       mem_addr;
    logic [DATA_WIDTH-1:0]       mem_wdata;
    logic                        mem_ready;
    logic [DATA_WIDTH-1:0]       mem_rdata;
    logic                        busy;
    logic [IW-1:0]               grant_id;
    modport slave (
        input  req_valid, req_rw, req_addr, req_wdata, mem_ready, mem_rdata,
        output req_ack, req_err, rsp_rdata, mem_valid, mem_rw, mem_addr, mem_wdata, busy, grant_id
    );
    modport master (
        output req_valid, req_rw, req_addr, req_wdata, mem_ready, mem_rdata,
        input  req_ack, req_err, rsp_rdata, mem_valid, mem_rw, mem_addr, mem_wdata, busy, grant_id
    );
endinterface

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin picker starting just after the last grant
module rr_arbiter #(
    parameter int N = 2,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);
    logic [IW-1:0] j;
    // scan last+1, last+2, ... wrapping, and keep the first requester found
    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        j = '0;
        for (int i = 1; i <= N; i++) begin
            j = IW'((int'(last) + i) % N);
            if (!any && req[j]) begin
                gnt[j] = 1'b1;
                idx = j;
                any = 1'b1;
            end
        end
    end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one mem_ctrl port between N_REQ requesters, round-robin, with a watchdog
module mem_port_arbiter
    import cache_structs_def::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int N_REQ = 2,
    parameter int TIMEOUT = 255
) (
    input logic clk,
    input logic rst,
    mem_port_arbiter_if.slave bus
);
    localparam int IW = $clog2(N_REQ);
    localparam int CW = $clog2(TIMEOUT + 1);

    if (N_REQ < 2 || N_REQ > ARB_MAX_REQ || TIMEOUT < 1) begin : g_bad_param
        $error("mem_port_arbiter: N_REQ must be 2..8 and TIMEOUT >= 1");
    end

    arb_state_e            state;
    logic [CW-1:0]         cnt;
    logic [N_REQ-1:0]      gnt;
    logic [N_REQ-1:0]      gnt_oh;
    logic [IW-1:0]         idx;
    logic                  any;
    logic                  timeout;
    logic                  sel_rw;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;

    rr_arbiter #(.N(N_REQ)) u_rr (
        .req  (bus.req_valid),
        .last (bus.grant_id),
        .gnt  (gnt),
        .idx  (idx),
        .any  (any)
    );

    assign gnt_oh  = N_REQ'(1) << bus.grant_id;
    assign timeout = cnt == CW'(TIMEOUT - 1);

    // one-hot mux of the winning requester's fields
    always_comb begin
        sel_rw = 1'b0;
        sel_addr = '0;
        sel_wdata = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt[i]) begin
                sel_rw = bus.req_rw[i];
                sel_addr = bus.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_wdata = bus.req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // grant/transfer/respond FSM; every output is registered here
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ARB_IDLE;
            cnt <= '0;
            bus.mem_valid <= 1'b0;
            bus.mem_rw <= 1'b0;
            bus.mem_addr <= '0;
            bus.mem_wdata <= '0;
            bus.rsp_rdata <= '0;
            bus.req_ack <= '0;
            bus.req_err <= '0;
            bus.busy <= 1'b0;
            bus.grant_id <= IW'(N_REQ - 1);
        end else begin
            case (state)
                ARB_IDLE: if (any) begin
                    bus.mem_rw <= sel_rw;
                    bus.mem_addr <= sel_addr;
                    bus.mem_wdata <= sel_wdata;
                    bus.grant_id <= idx;
                    bus.mem_valid <= 1'b1;
                    bus.busy <= 1'b1;
                    state <= ARB_BUSY;
                end
                ARB_BUSY: begin
                    cnt <= (cnt == CW'(TIMEOUT)) ? cnt : cnt + 1'b1;
                    if (bus.mem_ready || timeout) begin
                        bus.rsp_rdata <= bus.mem_ready ? bus.mem_rdata : '0;
                        bus.req_err <= bus.mem_ready ? '0 : gnt_oh;
                        bus.req_ack <= gnt_oh;
                        bus.mem_valid <= 1'b0;
                        state <= ARB_RESP;
                    end
                end
                ARB_RESP: begin
                    bus.req_ack <= '0;
                    bus.req_err <= '0;
                    cnt <= '0;
                    bus.busy <= 1'b0;
                    state <= ARB_IDLE;
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end
endmodule
